// File: rtl/hazard_stall_controller_if.sv
// Pipeline-side view of the hazard/stall controller: ID/EXE/MEM register
// indices and enables in, stall/flush/bubble and forwarding selects out.
interface hazard_stall_controller_if #(
  parameter int REG_ADDR_LEN = 4
);
  logic [REG_ADDR_LEN-1:0] id_src1;
  logic [REG_ADDR_LEN-1:0] id_src2;
  logic                    id_use_src1;
  logic                    id_use_src2;
  logic [REG_ADDR_LEN-1:0] exe_dest;
  logic                    exe_wb_en;
  logic                    exe_mem_r_en;
  logic [REG_ADDR_LEN-1:0] mem_dest;
  logic                    mem_wb_en;
  logic                    mem_req;
  logic                    branch_taken;
  logic                    stall_all;
  logic                    flush;
  logic                    freeze_front;
  logic                    bubble;
  logic [1:0]              fwd_sel_a;
  logic [1:0]              fwd_sel_b;

  modport master (
    output id_src1, id_src2, id_use_src1, id_use_src2,
    output exe_dest, exe_wb_en, exe_mem_r_en,
    output mem_dest, mem_wb_en, mem_req, branch_taken,
    input  stall_all, flush, freeze_front, bubble, fwd_sel_a, fwd_sel_b
  );

  modport slave (
    input  id_src1, id_src2, id_use_src1, id_use_src2,
    input  exe_dest, exe_wb_en, exe_mem_r_en,
    input  mem_dest, mem_wb_en, mem_req, branch_taken,
    output stall_all, flush, freeze_front, bubble, fwd_sel_a, fwd_sel_b
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Hazard/stall sequencer for the 5-stage core: SRAM wait FSM, RAW detection
// against EXE/MEM destinations, branch flush and registered forwarding selects.
module hazard_stall_controller #(
  parameter int REG_ADDR_LEN    = 4,
  parameter int MEM_WAIT_CYCLES = 4,
  parameter bit FWD_EN          = 1'b1
) (
  input logic                      clk,
  input logic                      rst,
  hazard_stall_controller_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_LAST = 2'd2
  } state_e;

  // An access spans its IDLE cycle, MEM_WAIT_CYCLES-2 WAIT cycles and an
  // unstalled LAST cycle, so the counter holds the WAIT cycles still to come.
  localparam bit          MULTI_CYCLE = (MEM_WAIT_CYCLES > 1);
  localparam int          CNT_W       = (MEM_WAIT_CYCLES > 2) ? $clog2(MEM_WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (MEM_WAIT_CYCLES > 2) ? CNT_W'(MEM_WAIT_CYCLES - 3) : '0;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         sel_a_q, sel_a_d;
  logic [1:0]         sel_b_q, sel_b_d;

  logic [REG_ADDR_LEN-1:0] src1, src2, exe_dest, mem_dest;
  logic m1e, m2e, m1m, m2m, raw;
  logic stall_c, flush_c, bubble_c;

  assign src1     = bus.id_src1;
  assign src2     = bus.id_src2;
  assign exe_dest = bus.exe_dest;
  assign mem_dest = bus.mem_dest;

  assign m1e = bus.id_use_src1 & bus.exe_wb_en & (src1 == exe_dest);
  assign m2e = bus.id_use_src2 & bus.exe_wb_en & (src2 == exe_dest);
  assign m1m = bus.id_use_src1 & bus.mem_wb_en & (src1 == mem_dest);
  assign m2m = bus.id_use_src2 & bus.mem_wb_en & (src2 == mem_dest);

  assign raw = FWD_EN ? ((m1e | m2e) & bus.exe_mem_r_en) : (m1e | m2e | m1m | m2m);

  // Every combinational output is gated by rst so nothing escapes during reset.
  assign stall_c  = rst & (((state_q == ST_IDLE) & bus.mem_req & MULTI_CYCLE)
                           | (state_q == ST_WAIT));
  assign flush_c  = rst & bus.branch_taken & ~stall_c;
  assign bubble_c = rst & raw & ~stall_c & ~flush_c;

  assign bus.stall_all    = stall_c;
  assign bus.flush        = flush_c;
  assign bus.freeze_front = bubble_c;
  assign bus.bubble       = bubble_c;
  assign bus.fwd_sel_a    = sel_a_q;
  assign bus.fwd_sel_b    = sel_b_q;

  // NOTE: every always_comb target gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_a_d = sel_a_q;
    sel_b_d = sel_b_q;

    unique case (state_q)
      ST_IDLE: if (bus.mem_req && MULTI_CYCLE) begin
        state_d = (MEM_WAIT_CYCLES == 2) ? ST_LAST : ST_WAIT;
        cnt_d   = CNT_LOAD;
      end
      ST_WAIT: if (cnt_q == '0) state_d = ST_LAST;
               else             cnt_d   = cnt_q - CNT_W'(1);
      ST_LAST: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (!stall_c) begin
      if (flush_c || bubble_c || !FWD_EN) begin
        sel_a_d = 2'b00;
        sel_b_d = 2'b00;
      end else begin
        sel_a_d = m1e ? 2'b01 : (m1m ? 2'b10 : 2'b00);
        sel_b_d = m2e ? 2'b01 : (m2m ? 2'b10 : 2'b00);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample their next value from the same pre-edge snapshot.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sel_a_q <= 2'b00;
      sel_b_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench: dut_a uses defaults (4-cycle SRAM, forwarding on),
// dut_b uses a single-cycle SRAM with forwarding off.
module tb_hazard_stall_controller;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  hazard_stall_controller_if #(.REG_ADDR_LEN(4)) bus_a ();
  hazard_stall_controller_if #(.REG_ADDR_LEN(4)) bus_b ();

  hazard_stall_controller #(
    .REG_ADDR_LEN(4), .MEM_WAIT_CYCLES(4), .FWD_EN(1'b1)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );

  hazard_stall_controller #(
    .REG_ADDR_LEN(4), .MEM_WAIT_CYCLES(1), .FWD_EN(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] s1; logic u1; logic [3:0] s2; logic u2;
    logic [3:0] ed; logic ew; logic el;
    logic [3:0] md; logic mw; logic mr;
    logic exp_bubble;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    bus_a.id_src1 = 4'd0;  bus_a.id_src2 = 4'd0;
    bus_a.id_use_src1 = 1'b0; bus_a.id_use_src2 = 1'b0;
    bus_a.exe_dest = 4'd0; bus_a.exe_wb_en = 1'b0; bus_a.exe_mem_r_en = 1'b0;
    bus_a.mem_dest = 4'd0; bus_a.mem_wb_en = 1'b0;
    bus_a.mem_req = 1'b0;  bus_a.branch_taken = 1'b0;
  endtask

  task automatic idle_b();
    bus_b.id_src1 = 4'd0;  bus_b.id_src2 = 4'd0;
    bus_b.id_use_src1 = 1'b0; bus_b.id_use_src2 = 1'b0;
    bus_b.exe_dest = 4'd0; bus_b.exe_wb_en = 1'b0; bus_b.exe_mem_r_en = 1'b0;
    bus_b.mem_dest = 4'd0; bus_b.mem_wb_en = 1'b0;
    bus_b.mem_req = 1'b0;  bus_b.branch_taken = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_a();
    idle_b();
    bus_a.mem_req = 1'b1; bus_a.branch_taken = 1'b1;
    bus_a.id_src1 = 4'd5; bus_a.id_use_src1 = 1'b1;
    bus_a.exe_dest = 4'd5; bus_a.exe_wb_en = 1'b1; bus_a.exe_mem_r_en = 1'b1;
    step();
    step();
    checks++;
    if ({bus_a.stall_all, bus_a.flush, bus_a.freeze_front, bus_a.bubble} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_comb_outputs got %b want 0000",
               {bus_a.stall_all, bus_a.flush, bus_a.freeze_front, bus_a.bubble});
    end
    checks++;
    if ({bus_a.fwd_sel_a, bus_a.fwd_sel_b} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_sel got %b want 0000", {bus_a.fwd_sel_a, bus_a.fwd_sel_b});
    end
    idle_a();
    rst = 1'b1;
    step();
  endtask

  task automatic test_forwarding();
    idle_a();
    bus_a.id_src1 = 4'd3; bus_a.id_use_src1 = 1'b1;
    bus_a.exe_dest = 4'd3; bus_a.exe_wb_en = 1'b1;
    bus_a.id_src2 = 4'd7; bus_a.id_use_src2 = 1'b1;
    bus_a.mem_dest = 4'd7; bus_a.mem_wb_en = 1'b1;
    #1;
    checks++;
    if (bus_a.bubble !== 1'b0) begin
      errors++; $display("FAIL fwd_no_bubble got %b want 0", bus_a.bubble);
    end
    step();
    checks++;
    if (bus_a.fwd_sel_a !== 2'b01 || bus_a.fwd_sel_b !== 2'b10) begin
      errors++;
      $display("FAIL fwd_exe_mem got a=%b b=%b want a=01 b=10", bus_a.fwd_sel_a, bus_a.fwd_sel_b);
    end
    // EXE and MEM both match src1: EXE must win; src2 unused must not forward.
    bus_a.mem_dest = 4'd3;
    bus_a.id_src2 = 4'd3; bus_a.id_use_src2 = 1'b0;
    step();
    checks++;
    if (bus_a.fwd_sel_a !== 2'b01 || bus_a.fwd_sel_b !== 2'b00) begin
      errors++;
      $display("FAIL fwd_priority got a=%b b=%b want a=01 b=00", bus_a.fwd_sel_a, bus_a.fwd_sel_b);
    end
    bus_a.exe_wb_en = 1'b0;
    step();
    checks++;
    if (bus_a.fwd_sel_a !== 2'b10) begin
      errors++; $display("FAIL fwd_mem_only got %b want 10", bus_a.fwd_sel_a);
    end
  endtask

  task automatic test_load_use();
    // fwd_sel_a is 10 from the previous test; the bubble must clear it.
    idle_a();
    bus_a.exe_dest = 4'd5; bus_a.exe_wb_en = 1'b1; bus_a.exe_mem_r_en = 1'b1;
    bus_a.id_src2 = 4'd5; bus_a.id_use_src2 = 1'b1;
    bus_a.id_src1 = 4'd3; bus_a.id_use_src1 = 1'b1;
    bus_a.mem_dest = 4'd3; bus_a.mem_wb_en = 1'b1;
    #1;
    checks++;
    if ({bus_a.freeze_front, bus_a.bubble, bus_a.stall_all, bus_a.flush} !== 4'b1100) begin
      errors++;
      $display("FAIL load_use_detect got %b want 1100",
               {bus_a.freeze_front, bus_a.bubble, bus_a.stall_all, bus_a.flush});
    end
    step();
    checks++;
    if (bus_a.fwd_sel_a !== 2'b00 || bus_a.fwd_sel_b !== 2'b00) begin
      errors++;
      $display("FAIL load_use_sel got a=%b b=%b want 00 00", bus_a.fwd_sel_a, bus_a.fwd_sel_b);
    end
    // Load moved to MEM, bubble sits in EXE: hazard clears, MEM forward next.
    bus_a.exe_wb_en = 1'b0; bus_a.exe_mem_r_en = 1'b0;
    bus_a.mem_dest = 4'd5; bus_a.mem_wb_en = 1'b1;
    #1;
    checks++;
    if (bus_a.bubble !== 1'b0 || bus_a.freeze_front !== 1'b0) begin
      errors++;
      $display("FAIL load_use_one_cycle got bubble=%b freeze=%b want 0 0",
               bus_a.bubble, bus_a.freeze_front);
    end
    step();
    checks++;
    if (bus_a.fwd_sel_b !== 2'b10) begin
      errors++; $display("FAIL load_use_after_sel got %b want 10", bus_a.fwd_sel_b);
    end
  endtask

  task automatic test_mem_stall();
    idle_a();
    bus_a.id_src1 = 4'd3; bus_a.id_use_src1 = 1'b1;
    bus_a.exe_dest = 4'd3; bus_a.exe_wb_en = 1'b1;
    step();
    checks++;
    if (bus_a.fwd_sel_a !== 2'b01) begin
      errors++; $display("FAIL stall_pre_sel got %b want 01", bus_a.fwd_sel_a);
    end
    // Inputs now ask for 10; the select must hold 01 until the LAST edge.
    bus_a.exe_wb_en = 1'b0;
    bus_a.mem_dest = 4'd3; bus_a.mem_wb_en = 1'b1;
    bus_a.mem_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (bus_a.stall_all !== (i < 3)) begin
        errors++; $display("FAIL stall_cycle%0d got %b want %b", i, bus_a.stall_all, (i < 3));
      end
      checks++;
      if (bus_a.fwd_sel_a !== ((i <= 3) ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL stall_hold_sel%0d got %b want %b", i, bus_a.fwd_sel_a,
                 ((i <= 3) ? 2'b01 : 2'b10));
      end
      step();
      bus_a.mem_req = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    idle_a();
    bus_a.mem_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (bus_a.stall_all !== ((i % 4) != 3)) begin
        errors++;
        $display("FAIL b2b_cycle%0d got %b want %b", i, bus_a.stall_all, ((i % 4) != 3));
      end
      if (i == 7) bus_a.mem_req = 1'b0;
      step();
    end
  endtask

  task automatic test_branch_stall();
    idle_a();
    bus_a.mem_req = 1'b1;
    bus_a.branch_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (bus_a.flush !== (i == 3) || bus_a.stall_all !== (i < 3)) begin
        errors++;
        $display("FAIL branch_stall%0d got flush=%b stall=%b want %b %b", i,
                 bus_a.flush, bus_a.stall_all, (i == 3), (i < 3));
      end
      step();
      bus_a.mem_req = 1'b0;
    end
    bus_a.branch_taken = 1'b0;
  endtask

  task automatic test_branch_priority();
    idle_a();
    bus_a.id_src1 = 4'd3; bus_a.id_use_src1 = 1'b1;
    bus_a.exe_dest = 4'd3; bus_a.exe_wb_en = 1'b1;
    bus_a.id_src2 = 4'd9; bus_a.id_use_src2 = 1'b1;
    bus_a.mem_dest = 4'd9; bus_a.mem_wb_en = 1'b1;
    step();
    bus_a.exe_mem_r_en = 1'b1;
    bus_a.branch_taken = 1'b1;
    #1;
    checks++;
    if ({bus_a.flush, bus_a.bubble, bus_a.freeze_front} !== 3'b100) begin
      errors++;
      $display("FAIL branch_over_raw got %b want 100",
               {bus_a.flush, bus_a.bubble, bus_a.freeze_front});
    end
    step();
    checks++;
    if (bus_a.fwd_sel_a !== 2'b00 || bus_a.fwd_sel_b !== 2'b00) begin
      errors++;
      $display("FAIL branch_sel got a=%b b=%b want 00 00", bus_a.fwd_sel_a, bus_a.fwd_sel_b);
    end
    // Flush alone (no hazard) must still zero a select that would forward 01.
    bus_a.exe_mem_r_en = 1'b0;
    bus_a.mem_wb_en = 1'b0;
    step();
    checks++;
    if (bus_a.fwd_sel_a !== 2'b00) begin
      errors++; $display("FAIL flush_clears_sel got %b want 00", bus_a.fwd_sel_a);
    end
    idle_a();
    step();
  endtask

  task automatic test_reset_in_wait();
    idle_a();
    bus_a.id_src1 = 4'd3; bus_a.id_use_src1 = 1'b1;
    bus_a.exe_dest = 4'd3; bus_a.exe_wb_en = 1'b1;
    step();
    bus_a.mem_req = 1'b1;
    step();
    bus_a.mem_req = 1'b0;
    #1;
    checks++;
    if (bus_a.stall_all !== 1'b1) begin
      errors++; $display("FAIL rst_wait_pre got %b want 1", bus_a.stall_all);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus_a.stall_all !== 1'b0) begin
      errors++; $display("FAIL rst_wait_forced got %b want 0", bus_a.stall_all);
    end
    step();
    rst = 1'b1;
    #1;
    checks++;
    if (bus_a.stall_all !== 1'b0 || bus_a.fwd_sel_a !== 2'b00) begin
      errors++;
      $display("FAIL rst_wait_post got stall=%b sel=%b want 0 00", bus_a.stall_all, bus_a.fwd_sel_a);
    end
    idle_a();
    step();
  endtask

  task automatic test_fwd_off();
    vec_t vecs [6];
    vecs[0] = '{4'd4, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{4'd4, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{4'd0, 1'b0, 4'd6, 1'b1, 4'd6, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{4'd0, 1'b0, 4'd6, 1'b0, 4'd6, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{4'd0, 1'b1, 4'd1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd8, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{4'd2, 1'b1, 4'd1, 1'b0, 4'd9, 1'b0, 1'b0, 4'd2, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      bus_b.id_src1 = vecs[i].s1; bus_b.id_use_src1 = vecs[i].u1;
      bus_b.id_src2 = vecs[i].s2; bus_b.id_use_src2 = vecs[i].u2;
      bus_b.exe_dest = vecs[i].ed; bus_b.exe_wb_en = vecs[i].ew; bus_b.exe_mem_r_en = vecs[i].el;
      bus_b.mem_dest = vecs[i].md; bus_b.mem_wb_en = vecs[i].mw; bus_b.mem_req = vecs[i].mr;
      #1;
      checks++;
      if (bus_b.bubble !== vecs[i].exp_bubble || bus_b.freeze_front !== vecs[i].exp_bubble
          || bus_b.stall_all !== 1'b0) begin
        errors++;
        $display("FAIL fwd_off_vec%0d got bubble=%b freeze=%b stall=%b want %b %b 0", i,
                 bus_b.bubble, bus_b.freeze_front, bus_b.stall_all,
                 vecs[i].exp_bubble, vecs[i].exp_bubble);
      end
      step();
    end
    checks++;
    if (bus_b.fwd_sel_a !== 2'b00 || bus_b.fwd_sel_b !== 2'b00) begin
      errors++;
      $display("FAIL fwd_off_sel got a=%b b=%b want 00 00", bus_b.fwd_sel_a, bus_b.fwd_sel_b);
    end
    idle_b();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_forwarding();
    test_load_use();
    test_mem_stall();
    test_back_to_back();
    test_branch_stall();
    test_branch_priority();
    test_reset_in_wait();
    test_fwd_off();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
